// File: rtl/dict_value_decompressor.sv
// dict_value_decompressor: expands packed codebook indices into a serial MSB-first bit stream
module dict_value_decompressor #(
   parameter int CHUNK_SIZE    = 4,
   parameter int CODEBOOK_SIZE = 8,
   parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE),
   parameter int NUM_CHUNKS    = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [NUM_CHUNKS*INDEX_BITS-1:0] compressed_input,
   output logic                             data_out,
   output logic                             data_valid,
   input  logic                             data_ready,
   output logic                             busy,
   output logic                             decompression_done
);
   localparam int CPW = $clog2(NUM_CHUNKS);
   localparam int BPW = $clog2(CHUNK_SIZE);
   // entry k lives at bits [k*CHUNK_SIZE +: CHUNK_SIZE]
   localparam logic [CODEBOOK_SIZE*CHUNK_SIZE-1:0] CODEBOOK = {
      4'b0111, 4'b1100, 4'b1000, 4'b1111, 4'b1011, 4'b1001, 4'b0010, 4'b0000
   };
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t                           state_q, state_d;
   logic [NUM_CHUNKS*INDEX_BITS-1:0] snap_q, snap_d;
   logic [CPW-1:0]                   chunk_q, chunk_d;
   logic [BPW-1:0]                   bit_q, bit_d;
   logic [INDEX_BITS-1:0]            idx;
   logic [CHUNK_SIZE-1:0]            cw;
   assign idx                = snap_q[chunk_q*INDEX_BITS +: INDEX_BITS];
   assign cw                 = CODEBOOK[idx*CHUNK_SIZE +: CHUNK_SIZE];
   assign data_valid         = state_q == RUN;
   assign busy               = state_q == RUN;
   assign decompression_done = state_q == DONE;
   // inverting the bit pointer walks the codeword from its MSB down
   assign data_out           = data_valid & cw[~bit_q];
   // next state: launch on start, advance pointers on each transfer, retire after the last bit
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      chunk_d = chunk_q;
      bit_d   = bit_q;
      unique case (state_q)
         IDLE: if (start) begin
            snap_d  = compressed_input;
            chunk_d = '0;
            bit_d   = '0;
            state_d = RUN;
         end
         RUN: if (data_ready) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == BPW'(CHUNK_SIZE-1)) begin
               chunk_d = chunk_q + 1'b1;
               if (chunk_q == CPW'(NUM_CHUNKS-1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state, snapshot and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         snap_q  <= '0;
         chunk_q <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         chunk_q <= chunk_d;
         bit_q   <= bit_d;
      end
   end
endmodule

// File: tb/tb_dict_value_decompressor.sv
// tb_dict_value_decompressor: randomized checks of the serial decompressor against a codebook model
module tb_dict_value_decompressor;
   logic        clk, rst_n, start, data_ready;
   logic [95:0] compressed_input;
   logic        data_out, data_valid, busy, decompression_done;
   int          checks, failures;
   logic [3:0]  cb [8] = '{4'b0000, 4'b0010, 4'b1001, 4'b1011, 4'b1111, 4'b1000, 4'b1100, 4'b0111};

   dict_value_decompressor dut (
      .clk(clk), .rst_n(rst_n), .start(start), .compressed_input(compressed_input),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .busy(busy), .decompression_done(decompression_done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // k-th streamed bit: chunk k/4, bit 3 first within each chunk
   function automatic logic model(input logic [95:0] vec, input int k);
      logic [2:0] i;
      logic [3:0] w;
      i = vec[(k/4)*3 +: 3];
      w = cb[i];
      return w[3 - k%4];
   endfunction

   task automatic launch(input logic [95:0] vec);
      @(negedge clk);
      compressed_input = vec;
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   // stream one block from the first RUN cycle; ends at the negedge after the last transfer
   // (or, if abort_at > 0, once that many transfers have been counted)
   task automatic drain(input logic [95:0] vec, input int pct, input bit disturb, input int abort_at,
                        input string name, output logic [127:0] cap, output int cycles);
      int k = 0;
      logic prev_stall = 0, prev_bit = 0;
      cap = '0;
      cycles = 0;
      while (k < 128 && cycles < 2000) begin
         data_ready = ($urandom_range(99) < pct);
         checks++;
         if (data_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid k=%0d valid=%b busy=%b expected 1/1", name, k, data_valid, busy);
         end
         checks++;
         if (data_out !== model(vec, k)) begin
            failures++;
            $display("FAIL %s_bit k=%0d got=%b expected=%b", name, k, data_out, model(vec, k));
         end
         if (prev_stall) begin
            checks++;
            if (data_out !== prev_bit) begin
               failures++;
               $display("FAIL %s_stall k=%0d got=%b held=%b", name, k, data_out, prev_bit);
            end
         end
         checks++;
         if (decompression_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_early_done k=%0d got=%b expected=0", name, k, decompression_done);
         end
         if (disturb) begin
            if (cycles == 5) compressed_input = {$urandom, $urandom, $urandom};
            if (cycles == 10) start = 1;
            if (cycles == 13) start = 0;
         end
         prev_stall = !data_ready;
         prev_bit = data_out;
         if (data_ready) begin
            cap = {cap[126:0], data_out};
            k++;
         end
         cycles++;
         if (abort_at > 0 && k == abort_at) return;
         @(negedge clk);
      end
      checks++;
      if (k != 128) begin
         failures++;
         $display("FAIL %s_timeout transfers=%0d expected=128", name, k);
      end
      checks++;
      if ({data_valid, busy, decompression_done, data_out} !== 4'b0010) begin
         failures++;
         $display("FAIL %s_done_cycle valid,busy,done,out=%b expected=0010", name,
                  {data_valid, busy, decompression_done, data_out});
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ({data_valid, busy, decompression_done, data_out} !== 4'b0000) begin
            failures++;
            $display("FAIL %s_after_done c=%0d valid,busy,done,out=%b expected=0000", name, c,
                     {data_valid, busy, decompression_done, data_out});
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      start = 1;
      data_ready = 1;
      compressed_input = {$urandom, $urandom, $urandom};
      repeat (3) @(negedge clk);
      checks++;
      if ({data_valid, busy, decompression_done, data_out} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs got=%b expected=0000", {data_valid, busy, decompression_done, data_out});
      end
      start = 0;
      rst_n = 1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (data_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle valid=%b busy=%b expected 0/0", data_valid, busy);
         end
      end
   endtask

   task automatic test_all_zero();
      logic [127:0] cap;
      int cyc;
      launch('0);
      drain('0, 100, 0, 0, "zero", cap, cyc);
      checks++;
      if (cyc != 128) begin
         failures++;
         $display("FAIL zero_throughput cycles=%0d expected=128", cyc);
      end
      checks++;
      if (cap !== '0) begin
         failures++;
         $display("FAIL zero_stream got=%h expected=0", cap);
      end
   endtask

   task automatic test_codebook();
      logic [95:0]  vec;
      logic [127:0] cap;
      int cyc;
      for (int i = 0; i < 32; i++) vec[i*3 +: 3] = 3'(i % 8);
      launch(vec);
      drain(vec, 100, 0, 0, "codebook", cap, cyc);
      checks++;
      if (cap !== {4{32'b0000_0010_1001_1011_1111_1000_1100_0111}}) begin
         failures++;
         $display("FAIL codebook_stream got=%h expected=%h", cap, {4{32'b0000_0010_1001_1011_1111_1000_1100_0111}});
      end
   endtask

   task automatic test_backpressure();
      logic [95:0]  vec;
      logic [127:0] cap;
      int cyc;
      for (int i = 0; i < 32; i++) vec[i*3 +: 3] = 3'd4;
      vec[2:0] = 3'd2;
      vec[5:3] = 3'd7;
      launch(vec);
      drain(vec, 50, 0, 0, "bp", cap, cyc);
      checks++;
      if (cap !== {8'b1001_0111, {30{4'b1111}}}) begin
         failures++;
         $display("FAIL bp_stream got=%h expected=%h", cap, {8'b1001_0111, {30{4'b1111}}});
      end
   endtask

   task automatic test_ignored_inputs();
      logic [95:0]  vec;
      logic [127:0] cap;
      int cyc;
      vec = {$urandom, $urandom, $urandom};
      launch(vec);
      drain(vec, 70, 1, 0, "ignored", cap, cyc);
   endtask

   task automatic test_reset_mid_stream();
      logic [95:0]  vec;
      logic [127:0] cap;
      int cyc;
      vec = {$urandom, $urandom, $urandom};
      launch(vec);
      drain(vec, 100, 0, 50, "abort", cap, cyc);
      #2 rst_n = 0;
      #1;
      checks++;
      if ({data_valid, busy, decompression_done, data_out} !== 4'b0000) begin
         failures++;
         $display("FAIL abort_async got=%b expected=0000", {data_valid, busy, decompression_done, data_out});
      end
      @(negedge clk);
      rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({data_valid, busy, decompression_done} !== 3'b000) begin
            failures++;
            $display("FAIL abort_idle got=%b expected=000", {data_valid, busy, decompression_done});
         end
      end
      vec = {$urandom, $urandom, $urandom};
      launch(vec);
      drain(vec, 100, 0, 0, "restart", cap, cyc);
   endtask

   task automatic test_back_to_back();
      logic [95:0]  vec;
      logic [127:0] cap;
      int cyc;
      for (int b = 0; b < 3; b++) begin
         vec = {$urandom, $urandom, $urandom};
         launch(vec);
         drain(vec, 80, 0, 0, "b2b", cap, cyc);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_all_zero();
      test_codebook();
      test_backpressure();
      test_ignored_inputs();
      test_reset_mid_stream();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
